// File: rtl/sd_photo_load_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_photo_load_sched
// Brief    : Queues photo-index load requests, maps each index to a start sector
//            through a writable table and walks the SD reader one sector at a time.
//            Define SD_RD_TIMEOUT_EN to add the per-sector watchdog with retry/abort.
// Revision : 1.0  initial release
// ============================================================================
module sd_photo_load_sched #(
  parameter logic [15:0] SEC_NUM     = 16'd1801,
  parameter logic [31:0] SEC_BASE    = 32'd32896,
  parameter logic [31:0] SEC_STRIDE  = 32'd4608
`ifdef SD_RD_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5000000,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_idx,
  output logic        req_ready,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_idx,
  input  logic [31:0] cfg_sec_addr,
  input  logic        rd_busy,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        load_busy,
  output logic [2:0]  load_idx,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [2:0] C_FIFO_DEPTH = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  fifo_q [4];
  logic [2:0]  fifo_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] table_q [8];
  logic [31:0] table_d [8];
  logic        busy_d0_q, busy_d0_d;
  logic        busy_d1_q, busy_d1_d;
  logic [15:0] sec_cnt_q, sec_cnt_d;
  logic [31:0] rd_sec_addr_q, rd_sec_addr_d;
  logic        rd_start_en_q, rd_start_en_d;
  logic        load_busy_q, load_busy_d;
  logic [2:0]  load_idx_q, load_idx_d;
  logic        load_done_q, load_done_d;
  logic        load_err_q, load_err_d;
`ifdef SD_RD_TIMEOUT_EN
  logic [23:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  retry_q, retry_d;
`endif

  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_busy_fall;
  logic [2:0]  w_head_idx;

  assign w_full      = (count_q == C_FIFO_DEPTH);
  assign w_push      = req_valid & ~w_full;
  assign w_busy_fall = busy_d1_q & ~busy_d0_q;
  assign w_head_idx  = fifo_q[rd_ptr_q];

  assign req_ready   = ~w_full;
  assign rd_start_en = rd_start_en_q;
  assign rd_sec_addr = rd_sec_addr_q;
  assign load_busy   = load_busy_q;
  assign load_idx    = load_idx_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;

  always_comb begin
    state_d       = state_q;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    table_d       = table_q;
    busy_d0_d     = rd_busy;
    busy_d1_d     = busy_d0_q;
    sec_cnt_d     = sec_cnt_q;
    rd_sec_addr_d = rd_sec_addr_q;
    rd_start_en_d = 1'b0;
    load_busy_d   = load_busy_q;
    load_idx_d    = load_idx_q;
    load_done_d   = 1'b0;
    load_err_d    = 1'b0;
    w_pop         = 1'b0;
`ifdef SD_RD_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    retry_d       = retry_q;
`endif

    // Lookups below read table_q, so a same-cycle cfg write is not yet visible.
    if (cfg_we) begin
      table_d[cfg_idx] = cfg_sec_addr;
    end

    if (w_push) begin
      fifo_d[wr_ptr_q] = req_idx;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) begin
          w_pop         = 1'b1;
          rd_ptr_d      = rd_ptr_q + 2'd1;
          load_idx_d    = w_head_idx;
          rd_sec_addr_d = table_q[w_head_idx];
          sec_cnt_d     = 16'd0;
          load_busy_d   = 1'b1;
          rd_start_en_d = 1'b1;
`ifdef SD_RD_TIMEOUT_EN
          retry_d       = 2'd0;
`endif
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef SD_RD_TIMEOUT_EN
        wait_cnt_d = 24'd0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (w_busy_fall) begin
          if (sec_cnt_q == SEC_NUM - 16'd1) begin
            load_done_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            sec_cnt_d     = sec_cnt_q + 16'd1;
            rd_sec_addr_d = rd_sec_addr_q + 32'd1;
            rd_start_en_d = 1'b1;
`ifdef SD_RD_TIMEOUT_EN
            retry_d       = 2'd0;
`endif
            state_d       = S_ISSUE;
          end
        end
`ifdef SD_RD_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_CYC - 24'd1) begin
          if (retry_q == MAX_RETRY) begin
            load_done_d = 1'b1;
            load_err_d  = 1'b1;
            state_d     = S_DONE;
          end else begin
            // Re-issue the same sector; address and sector count are unchanged.
            retry_d       = retry_q + 2'd1;
            rd_start_en_d = 1'b1;
            state_d       = S_ISSUE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 24'd1;
        end
`endif
      end
      S_DONE: begin
        load_busy_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_push && !w_pop) begin
      count_d = count_q + 3'd1;
    end else if (w_pop && !w_push) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 3'd0;
      end
      for (int i = 0; i < 8; i++) begin
        table_q[i] <= SEC_BASE + SEC_STRIDE * 32'(i);
      end
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
      busy_d0_q     <= 1'b0;
      busy_d1_q     <= 1'b0;
      sec_cnt_q     <= 16'd0;
      rd_sec_addr_q <= 32'd0;
      rd_start_en_q <= 1'b0;
      load_busy_q   <= 1'b0;
      load_idx_q    <= 3'd0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
`ifdef SD_RD_TIMEOUT_EN
      wait_cnt_q    <= 24'd0;
      retry_q       <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      fifo_q        <= fifo_d;
      table_q       <= table_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      busy_d0_q     <= busy_d0_d;
      busy_d1_q     <= busy_d1_d;
      sec_cnt_q     <= sec_cnt_d;
      rd_sec_addr_q <= rd_sec_addr_d;
      rd_start_en_q <= rd_start_en_d;
      load_busy_q   <= load_busy_d;
      load_idx_q    <= load_idx_d;
      load_done_q   <= load_done_d;
      load_err_q    <= load_err_d;
`ifdef SD_RD_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      retry_q       <= retry_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_photo_load_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sd_photo_load_sched
// Brief    : Self-checking bench for sd_photo_load_sched with a sector-reader
//            responder and a request/table/sector scoreboard model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_photo_load_sched;

  localparam logic [15:0] SEC_NUM    = 16'd4;
  localparam logic [31:0] SEC_BASE   = 32'd32896;
  localparam logic [31:0] SEC_STRIDE = 32'd4608;
`ifdef SD_RD_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 100;
  localparam int MAX_RETRY   = 3;
`endif
  localparam int RD_AUTO = 0;
  localparam int RD_HOLD = 1;
  localparam int RD_OFF  = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_idx;
  logic        req_ready;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_sec_addr;
  logic        rd_busy;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        load_busy;
  logic [2:0]  load_idx;
  logic        load_done;
  logic        load_err;

  sd_photo_load_sched #(
    .SEC_NUM     (SEC_NUM),
    .SEC_BASE    (SEC_BASE),
    .SEC_STRIDE  (SEC_STRIDE)
`ifdef SD_RD_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (24'd100),
    .MAX_RETRY   (2'd3)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_idx      (req_idx),
    .req_ready    (req_ready),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_sec_addr (cfg_sec_addr),
    .rd_busy      (rd_busy),
    .rd_start_en  (rd_start_en),
    .rd_sec_addr  (rd_sec_addr),
    .load_busy    (load_busy),
    .load_idx     (load_idx),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: table, accepted request queue, current load progress.
  logic [31:0] m_tbl [8];
  int          m_q [$];
  bit          m_active;
  int          m_idx;
  int          m_last_idx;
  logic [31:0] m_base;
  int          m_done_secs;
  bit          m_outst;
  int          m_starts;
  longint      m_last_start;
  longint      cyc = 0;
  bit          prev_busy;
  bit          prev_start;

  logic [31:0] start_log [$];
  int          done_log [$];
  int          err_log [$];

  int          rd_mode = RD_AUTO;
  int          busy_cnt = 0;
  logic        rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_tbl[i] = SEC_BASE + SEC_STRIDE * 32'(i);
    m_q.delete();
    m_active    = 1'b0;
    m_idx       = 0;
    m_last_idx  = 0;
    m_base      = 32'd0;
    m_done_secs = 0;
    m_outst     = 1'b0;
    m_starts    = 0;
    prev_busy   = 1'b0;
    prev_start  = 1'b0;
  endtask

  task automatic clear_logs();
    start_log.delete();
    done_log.delete();
    err_log.delete();
  endtask

  // Scoreboard: every cycle, compare what the DUT does against the model.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_busy  = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (prev_busy && !rd_busy && m_outst) begin
        m_done_secs++;
        m_outst  = 1'b0;
        m_starts = 0;
      end
      if (rd_start_en) begin
        check("start_one_cycle", 32'(prev_start), 32'd0);
        if (!m_active) begin
          if (m_q.size() == 0) begin
            check("start_without_request", 32'(rd_start_en), 32'd0);
          end else begin
            m_idx       = m_q.pop_front();
            m_base      = m_tbl[m_idx];
            m_active    = 1'b1;
            m_done_secs = 0;
            m_starts    = 0;
            m_outst     = 1'b0;
            check("load_idx_at_start", 32'(load_idx), 32'(m_idx));
          end
        end
        if (m_active) begin
          if (m_outst) begin
`ifdef SD_RD_TIMEOUT_EN
            check("retry_gap_min", 32'((cyc - m_last_start) >= TIMEOUT_CYC), 32'd1);
            check("retry_gap_max", 32'((cyc - m_last_start) <= TIMEOUT_CYC + 1), 32'd1);
`else
            check("restart_without_edge", 32'(rd_start_en), 32'd0);
`endif
          end
          check("rd_sec_addr", rd_sec_addr, m_base + 32'(m_done_secs));
          check("sector_in_range", 32'(m_done_secs < int'(SEC_NUM)), 32'd1);
          check("load_busy_during_load", 32'(load_busy), 32'd1);
          m_outst      = 1'b1;
          m_starts++;
          m_last_start = cyc;
          start_log.push_back(rd_sec_addr);
        end
      end
      if (load_done) begin
        if (!m_active) begin
          check("done_without_load", 32'(load_done), 32'd0);
        end else begin
          check("load_idx_at_done", 32'(load_idx), 32'(m_idx));
          if (m_done_secs == int'(SEC_NUM)) begin
            check("load_err_ok", 32'(load_err), 32'd0);
          end else begin
`ifdef SD_RD_TIMEOUT_EN
            check("abort_start_count", 32'(m_starts), 32'(MAX_RETRY + 1));
            check("load_err_abort", 32'(load_err), 32'd1);
`else
            check("done_early", 32'(m_done_secs), 32'(SEC_NUM));
`endif
          end
          done_log.push_back(m_idx);
          err_log.push_back(int'(load_err));
          m_active   = 1'b0;
          m_outst    = 1'b0;
          m_last_idx = m_idx;
        end
      end else if (!m_active && !rd_start_en) begin
        check("idle_load_busy", 32'(load_busy), 32'd0);
        check("idle_load_err", 32'(load_err), 32'd0);
        check("idle_load_idx_held", 32'(load_idx), 32'(m_last_idx));
      end
      if (req_valid && req_ready) m_q.push_back(int'(req_idx));
      if (cfg_we) m_tbl[cfg_idx] = cfg_sec_addr;
      prev_busy  = rd_busy;
      prev_start = rd_start_en;
    end
  end

  // SD reader stand-in: busy for three cycles after each start, or held/forced low.
  initial begin
    rd_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_mode == RD_HOLD) begin
        rd_busy  = 1'b1;
        busy_cnt = 0;
      end else if (rd_mode == RD_OFF) begin
        rd_busy  = 1'b0;
        busy_cnt = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) rd_busy = 1'b0;
      end else if (rd_start_en) begin
        rd_busy  = 1'b1;
        busy_cnt = 3;
      end else begin
        rd_busy = 1'b0;
      end
    end
  end

  task automatic push_one(input logic [2:0] idx, output logic r);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_idx   = idx;
    @(negedge clk);
    r = req_ready;
  endtask

  task automatic req_idle();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic request(input logic [2:0] idx);
    logic r;
    push_one(idx, r);
    check("req_ready_single", 32'(r), 32'd1);
    req_idle();
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [31:0] val);
    @(posedge clk);
    #1;
    cfg_we       = 1'b1;
    cfg_idx      = idx;
    cfg_sec_addr = val;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_log.size() < n; i++) @(negedge clk);
    check("done_count", 32'(done_log.size()), 32'(n));
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int i = 0; i < budget && start_log.size() < n; i++) @(negedge clk);
    check("start_count", 32'(start_log.size()), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_start_en"}, 32'(rd_start_en), 32'd0);
    check({tag, "_rd_sec_addr"}, rd_sec_addr, 32'd0);
    check({tag, "_load_busy"}, 32'(load_busy), 32'd0);
    check({tag, "_load_idx"}, 32'(load_idx), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  logic [31:0] exp_addr [4];
  int          exp_order [5];
  logic        exp_rdy [5];

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_idx      = 3'd0;
    cfg_we       = 1'b0;
    cfg_idx      = 3'd0;
    cfg_sec_addr = 32'd0;
    model_reset();
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Idx 0 starts at the table base.
    request(3'd0);
    wait_done(1, 200);
    check("t1_first_addr", start_log[0], 32'd32896);
    check("t1_sectors", 32'(start_log.size()), 32'd4);

    // Idx 2: four consecutive sectors, clean completion.
    clear_logs();
    request(3'd2);
    wait_done(1, 200);
    exp_addr = '{32'd42112, 32'd42113, 32'd42114, 32'd42115};
    for (int k = 0; k < 4; k++) check("t2_addr", start_log[k], exp_addr[k]);
    check("t2_done_idx", 32'(done_log[0]), 32'd2);
    check("t2_done_err", 32'(err_log[0]), 32'd0);
    repeat (5) @(negedge clk);
    check("t2_load_idx_held", 32'(load_idx), 32'd2);

    // Five back-to-back pushes during a load: only four fit.
    clear_logs();
    request(3'd0);
    repeat (3) @(negedge clk);
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      push_one(3'(i + 1), rdy);
      check("t3_req_ready", 32'(rdy), 32'(exp_rdy[i]));
    end
    req_idle();
    wait_done(5, 1000);
    exp_order = '{0, 1, 2, 3, 4};
    for (int i = 0; i < 5; i++) check("t3_order", 32'(done_log[i]), 32'(exp_order[i]));

    // Table write, then a mid-load rewrite that must not disturb the load.
    cfg_write(3'd5, 32'd1000);
    clear_logs();
    request(3'd5);
    wait_starts(2, 200);
    cfg_write(3'd5, 32'd2000);
    wait_done(1, 200);
    exp_addr = '{32'd1000, 32'd1001, 32'd1002, 32'd1003};
    for (int k = 0; k < 4; k++) check("t4_addr", start_log[k], exp_addr[k]);

    // Sector address wraps through zero.
    cfg_write(3'd7, 32'hFFFF_FFFE);
    clear_logs();
    request(3'd7);
    wait_done(1, 200);
    exp_addr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};
    for (int k = 0; k < 4; k++) check("wrap_addr", start_log[k], exp_addr[k]);

    // Reader never finishes.
    @(negedge clk);
    rd_mode = RD_HOLD;
    clear_logs();
    request(3'd1);
    repeat (450) @(negedge clk);
`ifdef SD_RD_TIMEOUT_EN
    check("t5_done", 32'(done_log.size()), 32'd1);
    check("t5_err", 32'(err_log[0]), 32'd1);
    check("t5_starts", 32'(start_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) check("t5_same_addr", start_log[k], 32'd37504);
    check("t5_busy_after_abort", 32'(load_busy), 32'd0);
    rd_mode = RD_AUTO;
    repeat (20) @(negedge clk);
    check("t5_late_edge_ignored", 32'(start_log.size()), 32'd4);
    check("t5_no_second_done", 32'(done_log.size()), 32'd1);
`else
    check("t5_no_done", 32'(done_log.size()), 32'd0);
    check("t5_still_busy", 32'(load_busy), 32'd1);
    check("t5_single_start", 32'(start_log.size()), 32'd1);
    rd_mode = RD_AUTO;
    wait_done(1, 200);
    check("t5_err", 32'(err_log[0]), 32'd0);
    check("t5_addr_last", start_log[3], 32'd37507);
`endif

    // Reset in the middle of sector 3 with requests still queued.
    clear_logs();
    request(3'd6);
    push_one(3'd3, rdy);
    push_one(3'd4, rdy);
    req_idle();
    wait_starts(3, 200);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    rd_mode = RD_OFF;
    model_reset();
    clear_logs();
    #1;
    check_reset_outputs("midload_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    rd_mode = RD_AUTO;
    repeat (10) @(negedge clk);
    check("t6_fifo_empty", 32'(load_busy), 32'd0);
    check("t6_no_done", 32'(done_log.size()), 32'd0);
    request(3'd5);
    wait_done(1, 200);
    check("t6_table_default", start_log[0], 32'd55936);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL global_timeout: simulation time exceeded, got %0t required < 1000000", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
